// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the RV32M multiply/divide unit.
//   - MDUOP_* operation codes (RISC-V funct3 encoding of the M extension)
//   - FSM state encoding for the mdu control path
//   - ZERO_WORD reset value for result registers
//   - helpers that report whether an op treats rs1 / rs2 as signed
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [2:0] mduop_t;

    localparam mduop_t MDUOP_MUL    = 3'd0;
    localparam mduop_t MDUOP_MULH   = 3'd1;
    localparam mduop_t MDUOP_MULHSU = 3'd2;
    localparam mduop_t MDUOP_MULHU  = 3'd3;
    localparam mduop_t MDUOP_DIV    = 3'd4;
    localparam mduop_t MDUOP_DIVU   = 3'd5;
    localparam mduop_t MDUOP_REM    = 3'd6;
    localparam mduop_t MDUOP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // rs1 is signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input mduop_t op);
        return (op == MDUOP_MUL) || (op == MDUOP_MULH) || (op == MDUOP_MULHSU) ||
               (op == MDUOP_DIV) || (op == MDUOP_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV and REM (MULHSU keeps it unsigned)
    function automatic logic op_b_signed(input mduop_t op);
        return (op == MDUOP_MUL) || (op == MDUOP_MULH) ||
               (op == MDUOP_DIV) || (op == MDUOP_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_step
// One combinational restoring-division iteration on unsigned magnitudes.
// The {rem, quot} pair is shifted left by one; if the shifted remainder is
// at least the divisor it is reduced and a 1 enters the quotient LSB,
// otherwise the shifted remainder is kept and a 0 enters.
// Ports:
//   rem_i      W  partial remainder (always < divisor_i)
//   quot_i     W  dividend bits still to consume / quotient bits so far
//   divisor_i  W  divisor magnitude
//   rem_o      W  next partial remainder
//   quot_o     W  next quotient / dividend register
// ---------------------------------------------------------------------------
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quot_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quot_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // One extra bit so the shifted remainder (< 2*divisor) never overflows
    assign shifted = {rem_i, quot_i[W-1]};
    assign diff    = shifted - {1'b0, divisor_i};

    // A borrow out of the subtraction means the divisor did not fit: restore
    always_comb begin
        rem_o  = shifted[W-1:0];
        quot_o = {quot_i[W-2:0], 1'b0};
        if (!diff[W]) begin
            rem_o  = diff[W-1:0];
            quot_o = {quot_i[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu
// Iterative multiply/divide unit for RV32M. Works on operand magnitudes
// (shift-add multiply, restoring divide, one bit per cycle) and applies
// sign correction when the result is selected in DONE.
// Optional build macro MDU_FAST_MUL_EN: multiplies use a combinational
// 64-bit product and skip CALC; divides are unaffected.
// Ports:
//   clk             core clock, rising edge
//   rst             synchronous active-high reset
//   req_valid_i     request present
//   req_ready_o     unit can accept (IDLE and not flushing)
//   op_i            MDUOP_* operation code
//   DataA_i         rs1 operand (multiplicand / dividend)
//   DataB_i         rs2 operand (multiplier / divisor)
//   flush_i         abandon any in-flight op
//   result_o        result, held until the next completion
//   result_valid_o  one-cycle pulse when result_o is new
//   busy_o          high in CALC and DONE
// ---------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] DataA_i,
    input  logic [XLEN-1:0] DataB_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            busy_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    mdu_state_e          state_q;
    mdu_state_e          state_d;
    logic [CNT_W-1:0]    counter_q;
    mduop_t              op_q;
    logic                neg_a_q;
    logic                neg_b_q;
    logic [XLEN-1:0]     abs_a_q;
    logic [XLEN-1:0]     abs_b_q;
    logic [2*XLEN-1:0]   work_q;

    logic                accept;
    logic                a_neg_in;
    logic                b_neg_in;
    logic [XLEN-1:0]     abs_a_in;
    logic [XLEN-1:0]     abs_b_in;
    logic                b_zero_in;
    logic                div_ovf_in;
    logic                special_in;
    logic                fast_in;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN-1:0]     div_rem_next;
    logic [XLEN-1:0]     div_quot_next;
    logic [2*XLEN-1:0]   work_next;

    logic [2*XLEN-1:0]   mag;
    logic [2*XLEN-1:0]   prod_signed;
    logic                prod_neg;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     result_sel;

    assign req_ready_o = (state_q == MDU_IDLE) && !flush_i;
    assign busy_o      = (state_q != MDU_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    assign a_neg_in  = op_a_signed(op_i) && DataA_i[XLEN-1];
    assign b_neg_in  = op_b_signed(op_i) && DataB_i[XLEN-1];
    assign abs_a_in  = a_neg_in ? (~DataA_i + 1'b1) : DataA_i;
    assign abs_b_in  = b_neg_in ? (~DataB_i + 1'b1) : DataB_i;

    assign b_zero_in  = (DataB_i == '0);
    assign div_ovf_in = ((op_i == MDUOP_DIV) || (op_i == MDUOP_REM)) &&
                        (DataA_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (DataB_i == '1);
    assign special_in = op_i[2] && (b_zero_in || div_ovf_in);

`ifdef MDU_FAST_MUL_EN
    assign fast_in = !op_i[2];
`else
    assign fast_in = 1'b0;
`endif

    // Shift-add: the low half holds the multiplier and is consumed LSB first,
    // the high half accumulates; the carry shifts down into the product.
    assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} +
                      (work_q[0] ? {1'b0, abs_a_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, work_q[XLEN-1:1]};

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem_i     (work_q[2*XLEN-1:XLEN]),
        .quot_i    (work_q[XLEN-1:0]),
        .divisor_i (abs_b_q),
        .rem_o     (div_rem_next),
        .quot_o    (div_quot_next)
    );

    assign work_next = op_q[2] ? {div_rem_next, div_quot_next} : mul_next;

    // Sign correction and result selection from the finished work register.
    // Special divide cases preload work_q with the final {rem, quot} and
    // clear the sign flags so they flow through this same path unchanged.
    always_comb begin
        mag = work_q;
`ifdef MDU_FAST_MUL_EN
        if (!op_q[2]) begin
            mag = {{XLEN{1'b0}}, abs_a_q} * {{XLEN{1'b0}}, abs_b_q};
        end
`endif
        prod_neg    = neg_a_q ^ neg_b_q;
        prod_signed = prod_neg ? (~mag + 1'b1) : mag;
        quot        = work_q[XLEN-1:0];
        rem         = work_q[2*XLEN-1:XLEN];
        result_sel  = quot;
        case (op_q)
            MDUOP_MUL:                            result_sel = prod_signed[XLEN-1:0];
            MDUOP_MULH, MDUOP_MULHSU, MDUOP_MULHU: result_sel = prod_signed[2*XLEN-1:XLEN];
            MDUOP_DIV, MDUOP_DIVU:                result_sel = prod_neg ? (~quot + 1'b1) : quot;
            MDUOP_REM, MDUOP_REMU:                result_sel = neg_a_q ? (~rem + 1'b1) : rem;
            default:                              result_sel = quot;
        endcase
    end

    // Next-state logic: special divides and fast multiplies skip CALC
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    state_d = (special_in || fast_in) ? MDU_DONE : MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (flush_i) begin
                    state_d = MDU_IDLE;
                end else if (counter_q == LAST_ITER) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Datapath and state registers; a flush in CALC/DONE drops the op and
    // leaves result_o untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= MDU_IDLE;
            counter_q      <= '0;
            result_o       <= ZERO_WORD;
            result_valid_o <= 1'b0;
            op_q           <= MDUOP_MUL;
            neg_a_q        <= 1'b0;
            neg_b_q        <= 1'b0;
            abs_a_q        <= '0;
            abs_b_q        <= '0;
            work_q         <= '0;
        end else begin
            state_q        <= state_d;
            result_valid_o <= 1'b0;
            case (state_q)
                MDU_IDLE: begin
                    if (accept) begin
                        op_q      <= op_i;
                        abs_a_q   <= abs_a_in;
                        abs_b_q   <= abs_b_in;
                        counter_q <= '0;
                        if (special_in) begin
                            neg_a_q <= 1'b0;
                            neg_b_q <= 1'b0;
                            work_q  <= b_zero_in ? {DataA_i, {XLEN{1'b1}}}
                                                 : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                        end else begin
                            neg_a_q <= a_neg_in;
                            neg_b_q <= b_neg_in;
                            work_q  <= {{XLEN{1'b0}}, (op_i[2] ? abs_a_in : abs_b_in)};
                        end
                    end
                end
                MDU_CALC: begin
                    if (!flush_i) begin
                        work_q    <= work_next;
                        counter_q <= counter_q + 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (!flush_i) begin
                        result_o       <= result_sel;
                        result_valid_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu
// Directed self-checking bench for mdu with hand-computed expected results
// and latencies. Latency is counted in cycles after the accept edge: the
// first cycle after that edge is 1.
// ---------------------------------------------------------------------------
module tb_mdu;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT     = 34;
    localparam int SPECIAL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        flush;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;

    int check_count = 0;
    int error_count = 0;

    mdu #(.XLEN(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .op_i           (op),
        .DataA_i        (data_a),
        .DataB_i        (data_b),
        .flush_i        (flush),
        .result_o       (result),
        .result_valid_o (result_valid),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Present a request at a falling edge and hold it until it is accepted;
    // returns just after the accept edge
    task automatic applyStimulus(input logic [2:0] op_v, input logic [31:0] a,
                                 input logic [31:0] b);
        bit accepted;
        @(negedge clk);
        req_valid = 1'b1;
        op        = op_v;
        data_a    = a;
        data_b    = b;
        accepted  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        checkOutput("accept", accepted, 1'b1);
    endtask

    // Count cycles until result_valid is seen; 0 means it never came
    task automatic waitResult(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op_v,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        applyStimulus(op_v, a, b);
        checkOutput({tag, " busy"}, busy, 1'b1);
        waitResult(lat);
        checkOutput({tag, " latency"}, lat, exp_lat);
        checkOutput(tag, result, exp_res);
        @(negedge clk);
        checkOutput({tag, " pulse width"}, result_valid, 1'b0);
        checkOutput({tag, " held"}, result, exp_res);
    endtask

    initial begin
        int pulses;
        int lat;
        logic ready_at_pulse;
        logic prev_ready;

        rst       = 1'b1;
        req_valid = 1'b0;
        op        = MDUOP_MUL;
        data_a    = '0;
        data_b    = '0;
        flush     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset valid", result_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle ready", req_ready, 1'b1);

        runOp("MUL 7*-3",      MDUOP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        runOp("MULH 7*-3",     MDUOP_MULH,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
        runOp("MULHU max*max", MDUOP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        runOp("MULHSU -1*2",   MDUOP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
        runOp("DIV -7/2",      MDUOP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
        runOp("REM -7%2",      MDUOP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
        runOp("DIVU 100/7",    MDUOP_DIVU,   32'd100,      32'd7,        32'd14,        DIV_LAT);
        runOp("REMU 100%7",    MDUOP_REMU,   32'd100,      32'd7,        32'd2,         DIV_LAT);
        runOp("DIV ovf",       MDUOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        runOp("REM ovf",       MDUOP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SPECIAL_LAT);
        runOp("DIVU 5/0",      MDUOP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, SPECIAL_LAT);
        runOp("REM 5%0",       MDUOP_REM,    32'd5,        32'd0,        32'd5,         SPECIAL_LAT);

        // Flush in the middle of CALC: op dropped, result_o keeps 5
        applyStimulus(MDUOP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checkOutput("flush busy", busy, 1'b0);
        countPulses(40, pulses);
        checkOutput("flush pulses", pulses, 0);
        checkOutput("flush result held", result, 32'd5);

        // Request and flush together: flush wins, nothing accepted
        @(negedge clk);
        req_valid = 1'b1;
        op        = MDUOP_DIVU;
        data_a    = 32'd9;
        data_b    = 32'd3;
        flush     = 1'b1;
        #1 checkOutput("flush blocks ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flush+req busy", busy, 1'b0);
        countPulses(40, pulses);
        checkOutput("flush+req pulses", pulses, 0);

        // Reset in the middle of CALC
        applyStimulus(MDUOP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midop reset result", result, 32'h0);
        checkOutput("midop reset valid", result_valid, 1'b0);
        checkOutput("midop reset busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        countPulses(40, pulses);
        checkOutput("midop reset pulses", pulses, 0);

        // Back-to-back: DIVU then MUL with req_valid held throughout
        applyStimulus(MDUOP_DIVU, 32'd100, 32'd7);
        req_valid = 1'b1;
        op        = MDUOP_MUL;
        data_a    = 32'd7;
        data_b    = 32'hFFFF_FFFD;
        lat            = 0;
        prev_ready     = 1'b1;
        ready_at_pulse = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (result_valid) begin
                lat            = i;
                ready_at_pulse = req_ready;
                break;
            end
            prev_ready = req_ready;
        end
        checkOutput("b2b first latency", lat, DIV_LAT);
        checkOutput("b2b first result", result, 32'd14);
        checkOutput("b2b done not ready", prev_ready, 1'b0);
        checkOutput("b2b ready at pulse", ready_at_pulse, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        checkOutput("b2b second busy", busy, 1'b1);
        waitResult(lat);
        checkOutput("b2b second latency", lat, MUL_LAT);
        checkOutput("b2b second result", result, 32'hFFFF_FFEB);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit for the RV32M extension.
- Sits beside the combinational alu in the EX stage and acts as the responder to the pipeline's multi-cycle request/response interface.
- The pipeline issues an M-class op with two operands, stalls while busy_o is high, and captures the result on result_valid_o.
- Uses a shift-add multiply, a restoring divide, and sign correction at the end.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request present this cycle.
- req_ready_o  output  1  unit can accept; equals (state==IDLE) && !flush_i.
- op_i  input  3  MDUOP_* code (RISC-V funct3 encoding).
- DataA_i  input  XLEN  rs1 operand (multiplicand/dividend).
- DataB_i  input  XLEN  rs2 operand (multiplier/divisor).
- flush_i  input  1  pipeline kill; abandons any in-flight op.
- result_o  output  XLEN  result; holds its value until the next completion.
- result_valid_o  output  1  single-cycle pulse when result_o is new.
- busy_o  output  1  high in CALC and DONE states.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0, result_o=`ZeroWord, result_valid_o=0, busy_o=0. Reset mid-operation discards the op; no valid pulse follows.
- Accept: a request is accepted at an edge where req_valid_i && req_ready_o. op, operand signs and absolute values are latched.
- Operand signs:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept when the op is a special case.
  - CALC -> DONE when counter == XLEN-1.
  - DONE -> IDLE unconditionally. During this transition result_o is loaded and result_valid_o=1 for that one cycle.
- CALC iterations, one per cycle, counter 0..31:
  - Multiply: 64-bit accumulator; shift-add on the LSB of |B|.
  - Divide: restoring step on a {rem,quot} 64-bit register; compare/subtract |B|.
- Latency: accept edge to the result_valid_o cycle is 34 cycles for normal ops and 2 cycles for special cases.
- Result select (DONE state):
  - MUL: low 32 bits of the signed product.
  - MULH, MULHSU, MULHU: high 32 bits, two's-complement negated over 64 bits when the result sign is negative.
  - DIV, DIVU: quotient, negated if sign(A) xor sign(B) (signed ops only).
  - REM, REMU: remainder, carrying the sign of A (signed ops only).
- Special cases (no CALC):
  - Divide by zero: DIV/DIVU return 32'hFFFFFFFF; REM/REMU return A.
  - Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): DIV returns 32'h80000000; REM returns 0.
- Flush: flush_i=1 in CALC or DONE forces state IDLE at the next edge with no valid pulse. result_o keeps its previous value.
- Flush and request in the same cycle: flush wins; req_ready_o=0 and the request is not accepted.
- req_valid_i while busy is ignored; the requester must hold the request until ready.
- Back-to-back operation: in the DONE cycle req_ready_o=0. The next request can be accepted in the following IDLE cycle.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MUL, MULH, MULHSU and MULHU compute the 64-bit product combinationally from the latched operands.
  - Transition is IDLE -> DONE directly, giving 2-cycle latency.
  - Divide behaviour is unchanged.
- Undefined: all multiplies take the 34-cycle iterative path.
- Results must be bit-identical either way.

Decomposition:
- Add to core_param.v:
  - MDUOP_BUS [2:0].
  - MDUOP_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - MDU state encodings IDLE=0, CALC=1, DONE=2.
- Reuse `RegBus and `ZeroWord.
- One natural sub-module: mdu_div_step, a combinational single restoring-divide iteration (rem, quot, divisor in; next rem, next quot out). Instantiated once.

Test Plan:
- MUL 7 x -3 -> result_o=32'hFFFFFFEB with valid 34 cycles after accept; MULH of the same operands -> 32'hFFFFFFFF.
- MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE; MULHSU 32'hFFFFFFFF(-1) x 2 -> 32'hFFFFFFFF.
- DIV -7 / 2 -> 32'hFFFFFFFD; REM -7 % 2 -> 32'hFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 32'hFFFFFFFF and REM 5 % 0 -> 5, valid 2 cycles after accept. DIV 32'h80000000 / -1 -> 32'h80000000 and REM -> 0.
- Flush at CALC cycle 10 -> no valid pulse, result_o unchanged. Request plus flush in the same cycle -> not accepted. rst mid-CALC -> all outputs at reset values.
- Back-to-back DIVU then MUL with req_valid_i held -> two valid pulses, second accept exactly 1 cycle after the first pulse. With MDU_FAST_MUL_EN, the MUL valid arrives 2 cycles after accept.
